bg_map_scroller: RTL and testbench
==================================

Name: bg_map_scroller

Overview:
- Writer side of the background tile-map RAM: generates every tile-map entry the background renderer later reads.
- Entry layout, per 16-bit word:
  - [2:0] tile column in bg ROM
  - [5:3] tile row in bg ROM
  - [6] X flip
  - [7] Y flip
  - [8] enable
  - [15:9] zero
- Address of an entry = col + row*TILE_COLS.
- Owns the 4-bit fine-scroll x_offset; performs a one-tile coarse scroll by shifting the play-field rows left during vertical blank.
- Sits between the game controller (scroll_tick, game_over, vblank) and a dual-port tile RAM (its own write port plus a read port).

Parameters:
- TILE_COLS, 40, tile-map columns.
- TILE_ROWS, 30, tile-map rows.
- HUD_ROWS, 5, top rows never scrolled or regenerated (written 16'h0000).
- GROUND_ROWS, 3, bottom rows filled with ground tiles.
- LFSR_SEED, 16'hACE1, reset value of the tile-pattern LFSR (must be nonzero).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- scroll_tick  in  1  one-cycle pulse: advance scroll by one pixel
- game_over  in  1  level; freezes scrolling
- vblank  in  1  level; high outside the visible frame
- rd_data  in  16  tile RAM read data, valid one cycle after rd_addr
- rd_addr  out  16  tile RAM read address
- wr_addr  out  16  tile RAM write address
- wr_data  out  16  tile RAM write data
- wr_en  out  1  tile RAM write strobe
- x_offset  out  4  fine scroll offset to renderer
- busy  out  1  high in INIT or SHIFT

Behaviour:
- Reset (clk edge with reset=1):
  - state=INIT, x_offset=0, wr_en=0, wr_addr=0, wr_data=0, rd_addr=0, busy=1, shift_pending=0, lfsr=LFSR_SEED.
  - Reset in any state aborts the operation in progress with no further writes; INIT restarts from address 0.
- Generated entry for row r, using lfsr before advance:
  - r < HUD_ROWS: 16'h0000.
  - r >= TILE_ROWS-GROUND_ROWS: {7'b0, 1'b1, 2'b00, 3'd1, lfsr[2:0]} (enable, ROM row 1, ROM column lfsr[2:0]).
  - Otherwise: lfsr[15:13]==3'b000 → {7'b0, 1'b1, 2'b00, 3'd0, lfsr[2:0]} (obstacle); else 16'h0000.
  - The LFSR advances one step (Galois, taps 16,14,13,11) per generated entry in a non-HUD row, and only then.
- INIT:
  - Writes every address 0..TILE_COLS*TILE_ROWS-1 in ascending order, one per cycle, wr_en=1.
  - Each write carries the generated entry for its row.
  - Takes 1200 cycles at defaults, then moves to IDLE with busy=0.
  - Ignores vblank.
- IDLE, fine scroll:
  - On scroll_tick with game_over=0 and shift_pending=0: if x_offset<15, x_offset increments.
  - If x_offset==15: x_offset holds 15 and shift_pending is set.
  - scroll_tick is dropped while game_over=1, shift_pending=1, or busy=1.
- Shift start: shift_pending and vblank both high (checked in IDLE) → SHIFT, busy=1.
- SHIFT:
  - Rows HUD_ROWS..TILE_ROWS-1 are processed in order.
  - Per row, rd_addr = row*TILE_COLS+1 .. +TILE_COLS-1, one per cycle.
  - Each returned rd_data is written to its source address minus 1 on the following cycle.
  - After the last read, the next cycle writes the generated entry to column TILE_COLS-1 of that row.
  - The next row's first read overlaps that write: 1 entry per cycle, TILE_COLS cycles per row.
  - Total = (TILE_ROWS-HUD_ROWS)*TILE_COLS + 1 cycles (1001 at defaults).
  - wr_en is never asserted for an address in rows 0..HUD_ROWS-1 during SHIFT.
- Shift completion, same cycle as returning to IDLE: x_offset=0, shift_pending=0, busy=0.
  - Effective picture moves exactly 1 pixel (offset 15 on the old map equals offset 0 on the shifted map).
- vblank falling mid-SHIFT does not abort; the shift runs to completion.
- game_over rising while shift_pending=1: the pending shift still executes at the next vblank; afterwards ticks are ignored.
- wr_en is 0 in IDLE. rd_addr holds its last value outside SHIFT. Address and data widths are zero-extended.

Test Plan:
- Reset, run 1200 cycles → exactly 1200 writes.
  - Addr 0..199 data 0.
  - Addr 1080..1199 have bit8=1, bits[5:3]=1.
  - busy falls on cycle 1201.
- From IDLE, 10 scroll_ticks → x_offset=10, no RAM writes.
- 16 ticks with vblank=0 → x_offset stays 15, shift_pending=1, ticks 17..20 ignored.
- Raise vblank → busy for 1001 cycles.
  - Model RAM shows old addr 201 content at 200 and old 239 at 238.
  - 239 holds a new entry; rows 0..4 untouched; x_offset=0 at completion.
- game_over=1 then 20 ticks → x_offset unchanged, no shift.
- Assert reset at SHIFT cycle 500 → writes stop next cycle, INIT restarts at addr 0, x_offset=0.
- Same reset and stimulus twice → identical write sequences (LFSR determinism).

Source files
------------

// File: rtl/bg_map_scroller.sv
// Background tile-map writer: fills the map at start-up, owns the fine x scroll,
// and performs a one-tile coarse scroll by shifting play-field rows left in vblank.
module bg_map_scroller #(
  parameter int          TILE_COLS   = 40,
  parameter int          TILE_ROWS   = 30,
  parameter int          HUD_ROWS    = 5,
  parameter int          GROUND_ROWS = 3,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scroll_tick,
  input  logic        game_over,
  input  logic        vblank,
  input  logic [15:0] rd_data,
  output logic [15:0] rd_addr,
  output logic [15:0] wr_addr,
  output logic [15:0] wr_data,
  output logic        wr_en,
  output logic [3:0]  x_offset,
  output logic        busy
);

  localparam logic [15:0] MAP_SIZE_C     = 16'(TILE_COLS * TILE_ROWS);
  localparam logic [15:0] COLS_C         = 16'(TILE_COLS);
  localparam logic [15:0] LAST_COL_C     = 16'(TILE_COLS - 1);
  localparam logic [15:0] ROWS_C         = 16'(TILE_ROWS);
  localparam logic [15:0] HUD_C          = 16'(HUD_ROWS);
  localparam logic [15:0] GROUND_START_C = 16'(TILE_ROWS - GROUND_ROWS);
  localparam logic [15:0] HUD_BASE_C     = 16'(HUD_ROWS * TILE_COLS);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  state_t      state_r, state_next_s;
  logic [15:0] lfsr_r;
  logic [15:0] init_addr_r, init_col_r, init_row_r;
  logic [15:0] sh_row_r, sh_col_r, sh_base_r;
  logic [15:0] wr_addr_r, wr_data_r, rd_addr_r;
  logic        wr_en_r, copy_r, busy_r, shift_pending_r;
  logic [3:0]  x_offset_r;
  logic        init_done_s, shift_done_s, shift_start_s;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [15:0] gen_entry(input logic [15:0] row,
                                            input logic [2:0]  lf_hi,
                                            input logic [2:0]  lf_lo);
    logic [15:0] e;
    if (row < HUD_C) begin
      e = 16'h0000;
    end else if (row >= GROUND_START_C) begin
      e = {7'b0, 1'b1, 2'b00, 3'd1, lf_lo};
    end else if (lf_hi == 3'b000) begin
      e = {7'b0, 1'b1, 2'b00, 3'd0, lf_lo};
    end else begin
      e = 16'h0000;
    end
    return e;
  endfunction

  assign init_done_s   = (init_addr_r == MAP_SIZE_C);
  assign shift_done_s  = (sh_row_r == ROWS_C);
  assign shift_start_s = shift_pending_r & vblank;

  // Next-state decode for the INIT / IDLE / SHIFT sequencer.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_INIT:  if (init_done_s)   state_next_s = ST_IDLE;  else state_next_s = ST_INIT;
      ST_IDLE:  if (shift_start_s) state_next_s = ST_SHIFT; else state_next_s = ST_IDLE;
      ST_SHIFT: if (shift_done_s)  state_next_s = ST_IDLE;  else state_next_s = ST_SHIFT;
      default:  state_next_s = ST_INIT;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_r <= ST_INIT;
    else       state_r <= state_next_s;
  end

  // Datapath: map generation, fine scroll, and the row-shift pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_r          <= LFSR_SEED;
      init_addr_r     <= 16'd0;
      init_col_r      <= 16'd0;
      init_row_r      <= 16'd0;
      sh_row_r        <= 16'd0;
      sh_col_r        <= 16'd0;
      sh_base_r       <= 16'd0;
      wr_addr_r       <= 16'd0;
      wr_data_r       <= 16'd0;
      rd_addr_r       <= 16'd0;
      wr_en_r         <= 1'b0;
      copy_r          <= 1'b0;
      busy_r          <= 1'b1;
      shift_pending_r <= 1'b0;
      x_offset_r      <= 4'd0;
    end else begin
      case (state_r)
        ST_INIT: begin
          copy_r <= 1'b0;
          if (init_done_s) begin
            wr_en_r <= 1'b0;
            busy_r  <= 1'b0;
          end else begin
            wr_en_r     <= 1'b1;
            wr_addr_r   <= init_addr_r;
            wr_data_r   <= gen_entry(init_row_r, lfsr_r[15:13], lfsr_r[2:0]);
            if (init_row_r >= HUD_C) lfsr_r <= lfsr_step(lfsr_r);
            init_addr_r <= init_addr_r + 16'd1;
            if (init_col_r == LAST_COL_C) begin
              init_col_r <= 16'd0;
              init_row_r <= init_row_r + 16'd1;
            end else begin
              init_col_r <= init_col_r + 16'd1;
            end
          end
        end
        ST_IDLE: begin
          wr_en_r <= 1'b0;
          copy_r  <= 1'b0;
          if (shift_start_s) begin
            busy_r    <= 1'b1;
            sh_row_r  <= HUD_C;
            sh_col_r  <= 16'd0;
            sh_base_r <= HUD_BASE_C;
            rd_addr_r <= HUD_BASE_C + 16'd1;
          end else if (scroll_tick && !game_over && !shift_pending_r) begin
            if (x_offset_r == 4'd15) shift_pending_r <= 1'b1;
            else                     x_offset_r      <= x_offset_r + 4'd1;
          end
        end
        ST_SHIFT: begin
          if (shift_done_s) begin
            wr_en_r         <= 1'b0;
            copy_r          <= 1'b0;
            busy_r          <= 1'b0;
            x_offset_r      <= 4'd0;
            shift_pending_r <= 1'b0;
          end else if (sh_col_r == LAST_COL_C) begin
            // Close the row with a fresh entry; the next row's first read overlaps it.
            wr_en_r   <= 1'b1;
            copy_r    <= 1'b0;
            wr_addr_r <= sh_base_r + LAST_COL_C;
            wr_data_r <= gen_entry(sh_row_r, lfsr_r[15:13], lfsr_r[2:0]);
            lfsr_r    <= lfsr_step(lfsr_r);
            sh_col_r  <= 16'd0;
            sh_row_r  <= sh_row_r + 16'd1;
            sh_base_r <= sh_base_r + COLS_C;
            if (sh_row_r + 16'd1 != ROWS_C) rd_addr_r <= sh_base_r + COLS_C + 16'd1;
          end else begin
            // Copy: the word read last cycle lands one column to the left.
            wr_en_r   <= 1'b1;
            copy_r    <= 1'b1;
            wr_addr_r <= sh_base_r + sh_col_r;
            if (sh_col_r + 16'd1 < LAST_COL_C) rd_addr_r <= sh_base_r + sh_col_r + 16'd2;
            sh_col_r  <= sh_col_r + 16'd1;
          end
        end
        default: begin
          wr_en_r <= 1'b0;
          copy_r  <= 1'b0;
          busy_r  <= 1'b1;
        end
      endcase
    end
  end

  assign rd_addr  = rd_addr_r;
  assign wr_addr  = wr_addr_r;
  assign wr_data  = copy_r ? rd_data : wr_data_r;
  assign wr_en    = wr_en_r;
  assign x_offset = x_offset_r;
  assign busy     = busy_r;

endmodule

// File: tb/tb_bg_map_scroller.sv
// Bench for bg_map_scroller: tile RAM model, expected-write queue built from the
// map rules, and an x_offset model, all checked on every falling clock edge.
module tb_bg_map_scroller;
  localparam int COLS = 40, ROWS = 30, HUD = 5, GROUND = 3, MAP = COLS * ROWS;

  logic        clk = 1'b0, reset = 1'b1, scroll_tick = 1'b0, game_over = 1'b0, vblank = 1'b0;
  logic [15:0] rd_data, rd_addr, wr_addr, wr_data;
  logic        wr_en, busy;
  logic [3:0]  x_offset;

  bg_map_scroller dut (
    .clk(clk), .reset(reset), .scroll_tick(scroll_tick), .game_over(game_over),
    .vblank(vblank), .rd_data(rd_data), .rd_addr(rd_addr), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_en(wr_en), .x_offset(x_offset), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:MAP-1];
  always @(posedge clk) begin
    if (wr_en === 1'b1 && wr_addr < 16'(MAP)) mem[wr_addr] <= wr_data;
    if (rd_addr < 16'(MAP)) rd_data <= mem[rd_addr];
    else                    rd_data <= 16'hDEAD;
  end

  int          n_vec = 0, n_err = 0, wr_cnt = 0, exp_xoff = 0;
  bit          exp_pending = 1'b0, mon_on = 1'b0;
  logic [15:0] m_lfsr;
  logic [15:0] exp_map [0:MAP-1];
  logic [15:0] old_map [0:MAP-1];
  logic [31:0] exp_q[$], wr_log[$], rec1[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] step(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [15:0] gen(input int row, input logic [15:0] lf);
    if (row < HUD) return 16'h0000;
    if (row >= ROWS - GROUND) return 16'h0108 | {13'd0, lf[2:0]};
    if (lf[15:13] == 3'b000) return 16'h0100 | {13'd0, lf[2:0]};
    return 16'h0000;
  endfunction

  task automatic build_init();
    m_lfsr = 16'hACE1;
    exp_q.delete();
    for (int a = 0; a < MAP; a++) begin
      exp_map[a] = gen(a / COLS, m_lfsr);
      if (a / COLS >= HUD) m_lfsr = step(m_lfsr);
      exp_q.push_back({16'(a), exp_map[a]});
    end
  endtask

  task automatic build_shift();
    exp_q.delete();
    for (int r = HUD; r < ROWS; r++) begin
      for (int c = 0; c < COLS - 1; c++) begin
        exp_map[r*COLS + c] = exp_map[r*COLS + c + 1];
        exp_q.push_back({16'(r*COLS + c), exp_map[r*COLS + c]});
      end
      exp_map[r*COLS + COLS - 1] = gen(r, m_lfsr);
      m_lfsr = step(m_lfsr);
      exp_q.push_back({16'(r*COLS + COLS - 1), exp_map[r*COLS + COLS - 1]});
    end
  endtask

  task automatic monitor_cycle();
    logic [31:0] e;
    if (wr_en === 1'b1) begin
      wr_cnt++;
      wr_log.push_back({wr_addr, wr_data});
      if (exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_write: got addr %0d data %0h expected no write", wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        check("write_addr_data", {wr_addr, wr_data}, e);
      end
    end
    if (mon_on) check("x_offset_model", 32'(x_offset), 32'(exp_xoff));
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic tick_once();
    scroll_tick = 1'b1;
    cyc();
    scroll_tick = 1'b0;
    if (!game_over && !exp_pending) begin
      if (exp_xoff == 15) exp_pending = 1'b1;
      else                exp_xoff++;
    end
    cyc();
  endtask

  task automatic wait_init(input string tag);
    int n = 0;
    int bad = 0;
    for (int i = 1; i <= 2000; i++) begin
      cyc();
      if (!busy) begin n = i; break; end
    end
    check({tag, "_busy_fall_cycle"}, 32'(n), 32'd1201);
    check({tag, "_write_count"}, 32'(wr_cnt), 32'd1200);
    check({tag, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
    for (int a = 0; a < MAP; a++) if (mem[a] !== exp_map[a]) bad++;
    check({tag, "_map_vs_model"}, 32'(bad), 32'd0);
  endtask

  task automatic shift_run(input int abort_at, output int len);
    len = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (busy) begin len = 1; break; end
    end
    check("shift_busy_rise", 32'(busy), 32'd1);
    while (len > 0 && len < 1100) begin
      if (len == abort_at) return;
      if (len == 300) vblank = 1'b0;
      cyc();
      if (!busy) break;
      len++;
    end
  endtask

  initial begin
    int bad, len, w0;
    fork
      forever begin @(negedge clk); monitor_cycle(); end
    join_none

    reset = 1'b1;
    cyc(); cyc();
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_x_offset", 32'(x_offset), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_rd_addr", 32'(rd_addr), 32'd0);
    build_init();
    exp_xoff = 0; exp_pending = 1'b0; mon_on = 1'b1;
    wr_log.delete(); wr_cnt = 0;
    reset = 1'b0;
    wait_init("init1");
    rec1 = wr_log;

    bad = 0;
    for (int a = 0; a < HUD * COLS; a++) if (mem[a] !== 16'h0000) bad++;
    check("hud_rows_zero", 32'(bad), 32'd0);
    bad = 0;
    for (int a = (ROWS - GROUND) * COLS; a < MAP; a++)
      if (mem[a][15:9] !== 7'd0 || mem[a][8] !== 1'b1 || mem[a][7:6] !== 2'b00 || mem[a][5:3] !== 3'd1) bad++;
    check("ground_rows_fields", 32'(bad), 32'd0);

    repeat (10) tick_once();
    check("x_offset_after_10", 32'(x_offset), 32'd10);
    check("no_writes_during_ticks", 32'(wr_cnt), 32'd1200);
    repeat (10) tick_once();
    check("x_offset_saturated", 32'(x_offset), 32'd15);
    check("no_shift_without_vblank", 32'(busy), 32'd0);

    for (int a = 0; a < MAP; a++) old_map[a] = mem[a];
    build_shift();
    w0 = wr_cnt;
    vblank = 1'b1;
    shift_run(0, len);
    exp_xoff = 0; exp_pending = 1'b0;
    check("shift_busy_cycles", 32'(len), 32'd1001);
    check("shift_write_count", 32'(wr_cnt - w0), 32'd1000);
    check("shift_x_offset_zero", 32'(x_offset), 32'd0);
    check("shift_200_from_201", 32'(mem[200]), 32'(old_map[201]));
    check("shift_238_from_239", 32'(mem[238]), 32'(old_map[239]));
    check("shift_239_new_entry", 32'(mem[239]), 32'(exp_map[239]));
    bad = 0;
    for (int a = 0; a < HUD * COLS; a++) if (mem[a] !== old_map[a]) bad++;
    check("shift_hud_untouched", 32'(bad), 32'd0);
    bad = 0;
    for (int a = 0; a < MAP; a++) if (mem[a] !== exp_map[a]) bad++;
    check("shift_map_vs_model", 32'(bad), 32'd0);

    tick_once();
    check("pending_cleared_tick", 32'(x_offset), 32'd1);
    game_over = 1'b1;
    vblank = 1'b1;
    w0 = wr_cnt;
    repeat (20) tick_once();
    check("game_over_x_offset", 32'(x_offset), 32'd1);
    check("game_over_no_shift", 32'(busy), 32'd0);
    check("game_over_no_writes", 32'(wr_cnt - w0), 32'd0);

    game_over = 1'b0;
    vblank = 1'b0;
    repeat (15) tick_once();
    check("repending_x_offset", 32'(x_offset), 32'd15);
    game_over = 1'b1;
    repeat (3) tick_once();
    build_shift();
    vblank = 1'b1;
    shift_run(500, len);
    check("pending_shift_runs_under_game_over", 32'(len), 32'd500);
    reset = 1'b1;
    cyc();
    check("reset_stops_writes", 32'(wr_en), 32'd0);
    check("reset_x_offset", 32'(x_offset), 32'd0);
    check("reset_busy", 32'(busy), 32'd1);
    check("reset_wr_addr", 32'(wr_addr), 32'd0);
    build_init();
    exp_xoff = 0; exp_pending = 1'b0;
    wr_log.delete(); wr_cnt = 0;
    game_over = 1'b0; vblank = 1'b0;
    reset = 1'b0;
    wait_init("init2");
    bad = (wr_log.size() == rec1.size()) ? 0 : 1;
    for (int i = 0; i < wr_log.size() && i < rec1.size(); i++) if (wr_log[i] !== rec1[i]) bad++;
    check("lfsr_determinism", 32'(bad), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
